// File: rtl/systolic_pkg.sv
// Shared types and defaults for the 3x3 output-stationary systolic sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default array dimension, element width and MAC latency
//   FEED_LEN     : number of skewed feed cycles for the default dimension
//   elem()       : extract A[i][j] from a row-major packed matrix
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    localparam int DEF_N       = 3;
    localparam int DEF_W       = 8;
    localparam int DEF_MAC_LAT = 1;
    localparam int FEED_LEN    = 3*DEF_N - 2;

    function automatic logic [DEF_W-1:0] elem(input logic [DEF_N*DEF_N*DEF_W-1:0] mat,
                                              input int i, input int j);
        return mat[(i*DEF_N + j)*DEF_W +: DEF_W];
    endfunction

endpackage

// File: rtl/systolic_edge_feeder.sv
// Skewed edge generator for one side of the systolic array.
//   mat      : latched operand matrix, row-major, N*N*W
//   t        : feed cycle index
//   orient   : 0 = row feed (lane i gets M[i][t-i]), 1 = column feed (lane j gets M[t-j][j])
//   edge_vec : N lanes of W bits, lane l at [l*W +: W]; zero where t-l is out of range
module systolic_edge_feeder #(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int TW = 3
) (
    input  logic [N*N*W-1:0] mat,
    input  logic [TW-1:0]    t,
    input  logic             orient,
    output logic [N*W-1:0]   edge_vec
);

    for (genvar l = 0; l < N; l++) begin : g_lane
        logic [W-1:0] lane_val;

        always_comb begin
            int k;
            k        = int'(t) - l;
            lane_val = '0;
            if (k >= 0 && k < N)
                lane_val = orient ? mat[(k*N + l)*W +: W] : mat[(l*N + k)*W +: W];
        end

        assign edge_vec[l*W +: W] = lane_val;
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic MAC array.
// Latches A/B on start, clears the PEs, streams skewed A rows / B columns,
// waits for the array to drain, captures the result and pulses done.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : operation request, honoured only in IDLE
//   a_mat, b_mat   : operand matrices, row-major packed
//   c_arr          : live accumulator values from the array
//   a_edge, b_edge : left / top edge feeds
//   mac_clr        : accumulator clear to all PEs
//   mac_en         : PE accumulate/shift enable
//   busy, done     : status; done is a one-cycle pulse
//   c_out          : captured result, held until next capture or reset
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*N*W-1:0] a_mat,
    input  logic [N*N*W-1:0] b_mat,
    input  logic [N*N*W-1:0] c_arr,
    output logic [N*W-1:0]   a_edge,
    output logic [N*W-1:0]   b_edge,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             busy,
    output logic             done,
    output logic [N*N*W-1:0] c_out
);

    localparam int FLEN    = 3*N - 2;
    localparam int CNT_MAX = (FLEN > MAC_LAT) ? FLEN : MAC_LAT;
    localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [TW-1:0] FEED_LAST  = TW'(FLEN - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(MAC_LAT - 1);

    state_t             state, state_nx;
    logic [TW-1:0]      t, t_nx;
    logic [N*N*W-1:0]   a_q, b_q;
    logic [N*W-1:0]     a_feed, b_feed;
    logic               accept;
    logic               busy_nx, clr_nx, en_nx, done_nx;

    systolic_edge_feeder #(.N(N), .W(W), .TW(TW)) u_feed_a (
        .mat(a_q), .t(t), .orient(1'b0), .edge_vec(a_feed)
    );

    systolic_edge_feeder #(.N(N), .W(W), .TW(TW)) u_feed_b (
        .mat(b_q), .t(t), .orient(1'b1), .edge_vec(b_feed)
    );

    // t is shared: feed index in FEED, drain index in DRAIN.
    always_comb begin
        state_nx = state;
        t_nx     = t;
        accept   = 1'b0;
        case (state)
            IDLE:  if (start) begin
                       accept   = 1'b1;
                       state_nx = CLEAR;
                   end
            CLEAR: begin
                       state_nx = FEED;
                       t_nx     = '0;
                   end
            FEED:  if (t == FEED_LAST) begin
                       state_nx = DRAIN;
                       t_nx     = '0;
                   end else begin
                       t_nx = t + 1'b1;
                   end
            DRAIN: if (t == DRAIN_LAST) begin
                       state_nx = DONE;
                       t_nx     = '0;
                   end else begin
                       t_nx = t + 1'b1;
                   end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered copies of the current-state decode, so they
        // trail the state register by one cycle.
        busy_nx = accept || (state != IDLE);
        clr_nx  = (state == CLEAR);
        en_nx   = (state == FEED) || (state == DRAIN);
        done_nx = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_nx;
            t     <= t_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
            a_edge  <= '0;
            b_edge  <= '0;
            c_out   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            busy    <= busy_nx;
            done    <= done_nx;
            mac_clr <= clr_nx;
            mac_en  <= en_nx;
            a_edge  <= (state == FEED) ? a_feed : '0;
            b_edge  <= (state == FEED) ? b_feed : '0;
            if (accept) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            // Sampled on the same edge that raises done: the last PE sum became
            // visible one cycle after the final drain enable was issued.
            if (state == DONE)
                c_out <= c_arr;
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench: DUT + behavioural 3x3 output-stationary MAC array,
// a timeline model of expected sequencer outputs, and directed/random scenarios.
module tb_systolic_seq_ctrl;
    import systolic_pkg::*;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int ML   = 1;
    localparam int NN   = N*N*W;
    localparam int FL   = 3*N - 2;
    localparam int LAST = 3*N + ML;     // cycles from acceptance to done

    logic          clk, rst_n, start;
    logic [NN-1:0] a_mat, b_mat, c_arr, c_out;
    logic [N*W-1:0] a_edge, b_edge;
    logic          mac_clr, mac_en, busy, done;

    int vectors = 0;
    int errors  = 0;

    systolic_seq_ctrl #(.N(N), .W(W), .MAC_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_mat(a_mat), .b_mat(b_mat), .c_arr(c_arr),
        .a_edge(a_edge), .b_edge(b_edge),
        .mac_clr(mac_clr), .mac_en(mac_en),
        .busy(busy), .done(done), .c_out(c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NN-1:0] matmul(input logic [NN-1:0] a, input logic [NN-1:0] b);
        logic [NN-1:0] r;
        logic [31:0]   s;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++)
                    s = s + 32'(elem(a, i, k)) * 32'(elem(b, k, j));
                r[(i*N + j)*W +: W] = s[W-1:0];
            end
        return r;
    endfunction

    function automatic logic [N*W-1:0] skew(input logic [NN-1:0] m, input int t, input bit col);
        logic [N*W-1:0] v;
        v = '0;
        for (int l = 0; l < N; l++) begin
            int k;
            k = t - l;
            if (k >= 0 && k < N)
                v[l*W +: W] = col ? elem(m, k, l) : elem(m, l, k);
        end
        return v;
    endfunction

    function automatic logic [NN-1:0] rnd_mat();
        logic [NN-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = W'($urandom);
        return m;
    endfunction

    // Behavioural MAC array: a flows right, b flows down, sums stay put.
    logic [W-1:0] acc [N][N] = '{default: '0};
    logic [W-1:0] ar  [N][N] = '{default: '0};
    logic [W-1:0] br  [N][N] = '{default: '0};
    logic [W-1:0] ai  [N][N];
    logic [W-1:0] bi  [N][N];
    logic [NN-1:0] c_nx;

    initial c_arr = '0;

    always @(posedge clk) begin
        if (mac_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = '0; ar[i][j] = '0; br[i][j] = '0;
                end
        end else if (mac_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ai[i][j] = (j == 0) ? a_edge[i*W +: W] : ar[i][j-1];
                    bi[i][j] = (i == 0) ? b_edge[j*W +: W] : br[i-1][j];
                end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = acc[i][j] + ai[i][j] * bi[i][j];
                    ar[i][j]  = ai[i][j];
                    br[i][j]  = bi[i][j];
                end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_nx[(i*N + j)*W +: W] = acc[i][j];
        c_arr <= c_nx;
    end

    // Timeline model: rel = cycles since acceptance edge, -1 when no op.
    int            rel = -1;
    logic [NN-1:0] la = '0, lb = '0, exp_c = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel   = -1;
            exp_c = '0;
        end else begin
            if ((rel < 0 || rel == LAST) && start) begin
                rel = 0; la = a_mat; lb = b_mat;
            end else if (rel >= 0 && rel < LAST) begin
                rel++;
            end else begin
                rel = -1;
            end
            if (rel == LAST) exp_c = matmul(la, lb);
        end
    end

    always @(negedge clk) begin
        logic feeding;
        feeding = (rel >= 2 && rel <= FL + 1);
        chk("cyc_busy",    72'(busy),    72'(rel >= 0));
        chk("cyc_mac_clr", 72'(mac_clr), 72'(rel == 1));
        chk("cyc_mac_en",  72'(mac_en),  72'(rel >= 2 && rel <= FL + ML + 1));
        chk("cyc_done",    72'(done),    72'(rel == LAST));
        chk("cyc_a_edge",  72'(a_edge),  feeding ? 72'(skew(la, rel - 2, 1'b0)) : 72'd0);
        chk("cyc_b_edge",  72'(b_edge),  feeding ? 72'(skew(lb, rel - 2, 1'b1)) : 72'd0);
        chk("cyc_c_out",   c_out,        exp_c);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Issue one op from posedge+1 phase; observe up to 20 cycles after acceptance.
    task automatic run_op(input logic [NN-1:0] a, input logic [NN-1:0] b,
                          output int done_at, output int busy_cnt);
        a_mat = a; b_mat = b; start = 1'b1;
        step(1);
        start = 1'b0;
        done_at = -1; busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = k;
            step(1);
        end
    endtask

    localparam logic [NN-1:0] SEQ9  = 72'h090807060504030201;
    localparam logic [NN-1:0] IDENT = 72'h010000000100000001;

    initial begin
        int            dat, bc, dn;
        logic [NN-1:0] a1, b1;
        int            dts[$];

        rst_n = 1'b0; start = 1'b0; a_mat = '0; b_mat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  72'(busy), 72'd0);
        chk("rst_done",  72'(done), 72'd0);
        chk("rst_en",    72'({mac_clr, mac_en}), 72'd0);
        chk("rst_edges", 72'({a_edge, b_edge}), 72'd0);
        chk("rst_c_out", c_out, 72'd0);
        rst_n = 1'b1;
        step(2);

        // Identity times sequence
        run_op(IDENT, SEQ9, dat, bc);
        chk("id_done_lat",   72'(dat), 72'd10);
        chk("id_busy_cycles", 72'(bc), 72'd11);
        chk("id_c_out", c_out, SEQ9);

        // Overflow: 3*255*255 mod 256 = 3
        run_op({9{8'hFF}}, {9{8'hFF}}, dat, bc);
        chk("ovf_c_out", c_out, {9{8'h03}});

        // Skew of A = 1..9 on the left edge
        a_mat = SEQ9; b_mat = rnd_mat(); start = 1'b1;
        step(1);
        start = 1'b0;
        step(2); chk("skew_t0", 72'(a_edge), 72'h000001);
        step(2); chk("skew_t2", 72'(a_edge), 72'h070503);
        step(2); chk("skew_t4", 72'(a_edge), 72'h090000);
        step(1); chk("skew_t5", 72'(a_edge), 72'h000000);
        step(1); chk("skew_t6", 72'(a_edge), 72'h000000);
        step(12);

        // Start and operand change during FEED are ignored
        a1 = rnd_mat(); b1 = rnd_mat();
        a_mat = a1; b_mat = b1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        start = 1'b1; a_mat = rnd_mat(); b_mat = rnd_mat();
        step(1);
        start = 1'b0;
        dn = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) dn++;
            step(1);
        end
        chk("ign_done_cnt", 72'(dn), 72'd1);
        chk("ign_c_out", c_out, matmul(a1, b1));

        // Reset in the middle of FEED
        a_mat = rnd_mat(); b_mat = rnd_mat(); start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_status", 72'({busy, done, mac_clr, mac_en}), 72'd0);
        chk("mid_rst_edges",  72'({a_edge, b_edge}), 72'd0);
        chk("mid_rst_c_out",  c_out, 72'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (done) dn++;
        end
        chk("mid_rst_no_done", 72'(dn), 72'd0);
        a1 = rnd_mat(); b1 = rnd_mat();
        run_op(a1, b1, dat, bc);
        chk("post_rst_lat", 72'(dat), 72'd10);
        chk("post_rst_c_out", c_out, matmul(a1, b1));

        // Random single ops with random idle gaps
        for (int n = 0; n < 6; n++) begin
            step($urandom_range(0, 3));
            a1 = rnd_mat(); b1 = rnd_mat();
            run_op(a1, b1, dat, bc);
            chk("rnd_lat", 72'(dat), 72'd10);
            chk("rnd_c_out", c_out, matmul(a1, b1));
        end

        // Start held high: back-to-back ops, operands churning every cycle
        start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            if (k == 30) start = 1'b0;
            a_mat = rnd_mat(); b_mat = rnd_mat();
            step(1);
            if (done) dts.push_back(k);
        end
        chk("b2b_done_cnt", 72'(dts.size()), 72'd3);
        if (dts.size() == 3) begin
            chk("b2b_gap1", 72'(dts[1] - dts[0]), 72'd11);
            chk("b2b_gap2", 72'(dts[2] - dts[1]), 72'd11);
        end
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
